// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the switch datapath merge stage:
//   - default word width and burst limit
//   - arbiter FSM state encodings (2-bit, 2'd3 is illegal)
//   - saturating counter helper used by the burst counter
// -----------------------------------------------------------------------------
package switch_pkg;

   localparam int DATA_W_DEF = 5;
   localparam int BURST_DEF  = 4;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   // Increment v by one, but never beyond lim.
   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      logic [3:0] r;
      if (v >= lim) begin
         r = v;
      end else begin
         r = v + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_rr_2to1_if.sv
// -----------------------------------------------------------------------------
// mux_rr_2to1_if
// Bundles the FIFO-side and downstream-side signals of the 2:1 merge stage.
//   master : upstream FIFOs / downstream stage (drives words, valids, pause)
//   slave  : the merge stage itself (drives pops and the merged stream)
// Signals:
//   data_in0/1, valid_in0/1 : head word and non-empty flag of each FIFO
//   pause                   : downstream almost-full
//   pop0/pop1               : combinational read strobes to the FIFOs
//   data_out/valid_out      : registered merged word and its valid
//   grant                   : registered current owner (1 = input 1)
// -----------------------------------------------------------------------------
interface mux_rr_2to1_if
   import switch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] data_in0;
   logic              valid_in0;
   logic [DATA_W-1:0] data_in1;
   logic              valid_in1;
   logic              pause;
   logic              pop0;
   logic              pop1;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              grant;

   modport master (
      output data_in0, valid_in0, data_in1, valid_in1, pause,
      input  pop0, pop1, data_out, valid_out, grant
   );

   modport slave (
      input  data_in0, valid_in0, data_in1, valid_in1, pause,
      output pop0, pop1, data_out, valid_out, grant
   );
endinterface

// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
// Burst-limited round-robin arbiter between two FIFOs.
//   clk, reset_L       : clock, async active-low reset
//   i_valid0/i_valid1  : FIFO non-empty flags
//   i_pause            : downstream almost-full, blocks all pops
//   o_pop0/o_pop1      : combinational read strobes (at most one high)
//   o_grant            : registered owner, 1 when input 1 owns the output
// -----------------------------------------------------------------------------
module rr_burst_arbiter
   import switch_pkg::*;
#(
   parameter int BURST = BURST_DEF
)(
   input  logic clk,
   input  logic reset_L,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_pause,
   output logic o_pop0,
   output logic o_pop1,
   output logic o_grant
);

   localparam logic [3:0] BURST_CNT = 4'(BURST);

   state_t     r_state;
   logic [3:0] r_cnt;
   state_t     w_state_nxt;
   logic [3:0] w_cnt_nxt;
   logic       w_pop0;
   logic       w_pop1;
   logic       w_burst_done;

   assign w_burst_done = (r_cnt == BURST_CNT);

   // Pop decode: the owner pops while valid, except on the handover cycle
   // where the burst is exhausted and the other side is waiting.
   always_comb begin
      w_pop0 = 1'b0;
      w_pop1 = 1'b0;
      if (!reset_L || i_pause) begin
         w_pop0 = 1'b0;
         w_pop1 = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_pop0 = i_valid0;
               w_pop1 = ~i_valid0 & i_valid1;
            end
            ST_OWN0: begin
               w_pop0 = i_valid0 & ~(w_burst_done & i_valid1);
               w_pop1 = 1'b0;
            end
            ST_OWN1: begin
               w_pop0 = 1'b0;
               w_pop1 = i_valid1 & ~(w_burst_done & i_valid0);
            end
            default: begin
               w_pop0 = 1'b0;
               w_pop1 = 1'b0;
            end
         endcase
      end
   end

   // Next-state and burst-count logic; the illegal encoding falls back to
   // IDLE even while paused.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (i_pause) begin
               w_state_nxt = r_state;
               w_cnt_nxt   = r_cnt;
            end else if (i_valid0) begin
               w_state_nxt = ST_OWN0;
               w_cnt_nxt   = 4'd1;
            end else if (i_valid1) begin
               w_state_nxt = ST_OWN1;
               w_cnt_nxt   = 4'd1;
            end else begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         end
         ST_OWN0: begin
            if (i_pause) begin
               w_state_nxt = r_state;
               w_cnt_nxt   = r_cnt;
            end else if (i_valid0 && ((r_cnt < BURST_CNT) || !i_valid1)) begin
               w_state_nxt = ST_OWN0;
               w_cnt_nxt   = sat_inc(r_cnt, BURST_CNT);
            end else if (i_valid1) begin
               w_state_nxt = ST_OWN1;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         end
         ST_OWN1: begin
            if (i_pause) begin
               w_state_nxt = r_state;
               w_cnt_nxt   = r_cnt;
            end else if (i_valid1 && ((r_cnt < BURST_CNT) || !i_valid0)) begin
               w_state_nxt = ST_OWN1;
               w_cnt_nxt   = sat_inc(r_cnt, BURST_CNT);
            end else if (i_valid0) begin
               w_state_nxt = ST_OWN0;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 4'd0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State and burst counter registers.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign o_pop0  = w_pop0;
   assign o_pop1  = w_pop1;
   assign o_grant = (r_state == ST_OWN1);

endmodule

// File: rtl/mux_rr_2to1.sv
// -----------------------------------------------------------------------------
// mux_rr_2to1
// Two-input round-robin merge of two FIFO word streams into one registered
// output stream, with burst limiting and downstream back-pressure.
//   clk      : single clock
//   reset_L  : asynchronous active-low reset
//   bus      : mux_rr_2to1_if.slave (FIFO heads/valids, pause, pops,
//              data_out, valid_out, grant)
// Popped word appears on data_out one cycle after its pop; data_out holds
// its last value when nothing is popped.
// -----------------------------------------------------------------------------
module mux_rr_2to1
   import switch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int BURST  = BURST_DEF
)(
   input  logic         clk,
   input  logic         reset_L,
   mux_rr_2to1_if.slave bus
);

   logic              w_pop0;
   logic              w_pop1;
   logic              w_grant;
   logic [DATA_W-1:0] r_data_out;
   logic              r_valid_out;

   rr_burst_arbiter #(
      .BURST (BURST)
   ) u_arb (
      .clk      (clk),
      .reset_L  (reset_L),
      .i_valid0 (bus.valid_in0),
      .i_valid1 (bus.valid_in1),
      .i_pause  (bus.pause),
      .o_pop0   (w_pop0),
      .o_pop1   (w_pop1),
      .o_grant  (w_grant)
   );

   // Output register: capture the popped word, hold data when idle.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
      end else begin
         r_valid_out <= w_pop0 | w_pop1;
         if (w_pop0) begin
            r_data_out <= bus.data_in0;
         end else if (w_pop1) begin
            r_data_out <= bus.data_in1;
         end else begin
            r_data_out <= r_data_out;
         end
      end
   end

   assign bus.pop0      = w_pop0;
   assign bus.pop1      = w_pop1;
   assign bus.grant     = w_grant;
   assign bus.data_out  = r_data_out;
   assign bus.valid_out = r_valid_out;

endmodule
